// File: rtl/numa_rx_parser.sv
// numa_rx_parser
//   Parses frames from the PHY receive queue and forwards accepted frames to
//   the master queue as 18-bit words {flag[1:0], data[15:0]}.
//   Accepted frames produce:
//     {start, addr[31:16]}, {middle, addr[15:0]}, then len/2 payload words.
//   Frames that fail validation produce nothing.
//   Frames that end early inside the payload produce a single abort word.
//   Optional feature: define NUMA_RX_PARSER_STATS_EN to build the
//   stat_ok/stat_drop frame counters. Without it both ports are tied to 0.
module numa_rx_parser #(
  parameter logic [15:0] ETHERTYPE = 16'h3776,
  parameter logic [15:0] MAX_LEN   = 16'd1024
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic [8:0]  phy_dout,
  input  logic        phy_empty,
  output logic        phy_rd_en,
  output logic [17:0] mst_din,
  input  logic        mst_full,
  output logic        mst_wr_en,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_SKIP,
    S_DROP
  } state_t;

  localparam logic [1:0] FLAG_START = 2'b10;
  localparam logic [1:0] FLAG_MID   = 2'b00;
  localparam logic [1:0] FLAG_END   = 2'b01;
  localparam logic [1:0] FLAG_ABORT = 2'b11;

  localparam logic [4:0] IDX_ETYPE_HI = 5'd12;
  localparam logic [4:0] IDX_ETYPE_LO = 5'd13;
  localparam logic [4:0] IDX_ADDR_0   = 5'd14;
  localparam logic [4:0] IDX_ADDR_1   = 5'd15;
  localparam logic [4:0] IDX_ADDR_2   = 5'd16;
  localparam logic [4:0] IDX_ADDR_3   = 5'd17;
  localparam logic [4:0] IDX_LEN_HI   = 5'd18;
  localparam logic [4:0] IDX_LEN_LO   = 5'd19;

  // Parser state.
  state_t      state;
  state_t      state_nxt;
  logic        rd_q;        // a pop happened last cycle: phy_dout is live now
  logic [4:0]  hdr_idx;     // index of the header byte arriving next
  logic [15:0] etype_q;
  logic [31:0] addr_q;
  logic [7:0]  len_hi_q;
  logic [15:0] pay_rem;     // payload bytes still expected
  logic [7:0]  odd_byte;    // first byte of a half-built payload word
  logic        odd_vld;

  // Words that are generated without a PHY byte arriving at the same moment.
  logic        hdr_pend;    // second header word still to be emitted
  logic        abt_pend;    // abort word still to be emitted

  // Output register and its one-entry skid behind it.
  logic        out_vld;
  logic [17:0] out_word;
  logic        skid_vld;
  logic [17:0] skid_word;

  // Decoded per-cycle events.
  logic        in_vld;
  logic        in_end;
  logic [7:0]  in_byte;
  logic [15:0] len_w;
  logic        hdr_ok;
  logic        hdr_last;
  logic        hdr_done;
  logic        set_abt;
  logic        hdr_go;
  logic        abt_go;
  logic        out_free;
  logic        prod_vld;
  logic [17:0] prod_word;

  assign in_vld   = rd_q &  phy_dout[8];
  assign in_end   = rd_q & ~phy_dout[8];
  assign in_byte  = phy_dout[7:0];

  // Length is complete only while its low byte is on the bus.
  assign len_w    = {len_hi_q, in_byte};
  assign hdr_ok   = (etype_q == ETHERTYPE) && (len_w != 16'd0) &&
                    !len_w[0] && (len_w <= MAX_LEN);
  assign hdr_last = in_vld && (state == S_HDR) && (hdr_idx == IDX_LEN_LO);
  assign hdr_done = hdr_last && hdr_ok;

  // An early end in the payload always goes through abt_pend so it can
  // never collide with the second header word in the same cycle.
  assign set_abt  = in_end && (state == S_PAY);

  // Deferred words only issue when the skid has room; the header word
  // first, so the abort always follows the header it belongs to.
  assign hdr_go   = hdr_pend && !skid_vld;
  assign abt_go   = abt_pend && !hdr_pend && !skid_vld;

  // Pop only when a produced word is guaranteed a slot; a word can still be
  // produced one cycle after mst_full rises, and the skid absorbs it.
  assign phy_rd_en = sys_rst_n & ~phy_empty & ~mst_full & ~skid_vld;

  assign mst_wr_en = out_vld & ~mst_full;
  assign mst_din   = out_word;
  assign out_free  = ~out_vld | ~mst_full;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and word production (at most one word per cycle).
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    prod_vld  = 1'b0;
    prod_word = '0;

    case (state)
      S_IDLE: begin
        if (in_vld) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (in_end)        state_nxt = S_IDLE;
        else if (hdr_last) state_nxt = hdr_ok ? S_PAY : S_DROP;
      end
      S_PAY: begin
        if (in_end)                             state_nxt = S_IDLE;
        else if (in_vld && pay_rem == 16'd1)    state_nxt = S_SKIP;
      end
      S_SKIP, S_DROP: begin
        if (in_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (hdr_go) begin
      prod_vld  = 1'b1;
      prod_word = {FLAG_MID, addr_q[15:0]};
    end else if (abt_go) begin
      prod_vld  = 1'b1;
      prod_word = {FLAG_ABORT, 16'h0000};
    end else if (hdr_done) begin
      prod_vld  = 1'b1;
      prod_word = {FLAG_START, addr_q[31:16]};
    end else if (state == S_PAY && in_vld && odd_vld) begin
      prod_vld  = 1'b1;
      prod_word = {(pay_rem == 16'd1) ? FLAG_END : FLAG_MID, odd_byte, in_byte};
    end
  end

  // Header capture, payload byte pairing and deferred-word flags.
  // NOTE: the datapath registers are reset too; they are few and it keeps
  // every output deterministic straight out of reset.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_q     <= 1'b0;
      hdr_idx  <= '0;
      etype_q  <= '0;
      addr_q   <= '0;
      len_hi_q <= '0;
      pay_rem  <= '0;
      odd_byte <= '0;
      odd_vld  <= 1'b0;
      hdr_pend <= 1'b0;
      abt_pend <= 1'b0;
    end else begin
      rd_q <= phy_rd_en;

      if (in_vld) begin
        if (state == S_IDLE) begin
          // This byte is header byte 0; the next one is byte 1.
          hdr_idx <= 5'd1;
        end else if (state == S_HDR) begin
          hdr_idx <= hdr_idx + 5'd1;
          case (hdr_idx)
            IDX_ETYPE_HI: etype_q[15:8] <= in_byte;
            IDX_ETYPE_LO: etype_q[7:0]  <= in_byte;
            IDX_ADDR_0, IDX_ADDR_1,
            IDX_ADDR_2, IDX_ADDR_3: addr_q <= {addr_q[23:0], in_byte};
            IDX_LEN_HI:   len_hi_q      <= in_byte;
            default: ;
          endcase
          if (hdr_last) begin
            pay_rem <= len_w;
            odd_vld <= 1'b0;
          end
        end else if (state == S_PAY) begin
          pay_rem <= pay_rem - 16'd1;
          odd_vld <= ~odd_vld;
          if (!odd_vld) odd_byte <= in_byte;
        end
      end

      hdr_pend <= hdr_done | (hdr_pend & ~hdr_go);
      abt_pend <= set_abt  | (abt_pend & ~abt_go);
    end
  end

  // Output register with skid: a word that cannot be presented because the
  // output register is still held by mst_full waits in the skid.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_vld   <= 1'b0;
      out_word  <= '0;
      skid_vld  <= 1'b0;
      skid_word <= '0;
    end else if (out_free) begin
      if (skid_vld) begin
        out_vld   <= 1'b1;
        out_word  <= skid_word;
        skid_vld  <= prod_vld;
        if (prod_vld) skid_word <= prod_word;
      end else if (prod_vld) begin
        out_vld   <= 1'b1;
        out_word  <= prod_word;
      end else begin
        out_vld   <= 1'b0;
      end
    end else if (prod_vld) begin
      skid_vld  <= 1'b1;
      skid_word <= prod_word;
    end
  end

`ifdef NUMA_RX_PARSER_STATS_EN
  logic        inc_ok;
  logic        inc_drop;
  logic [15:0] ok_q;
  logic [15:0] drop_q;

  // Each frame is counted exactly once, when its terminating entry arrives.
  assign inc_ok   = in_end && (state == S_SKIP);
  assign inc_drop = in_end && (state == S_HDR || state == S_PAY || state == S_DROP);

  // Frame counters; 16-bit addition wraps from FFFF to 0 on its own.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      if (inc_ok)   ok_q   <= ok_q   + 16'd1;
      if (inc_drop) drop_q <= drop_q + 16'd1;
    end
  end

  assign stat_ok   = ok_q;
  assign stat_drop = drop_q;
`else
  assign stat_ok   = 16'h0000;
  assign stat_drop = 16'h0000;
`endif

endmodule

// File: tb/tb_numa_rx_parser.sv
// tb_numa_rx_parser
//   Directed bench for numa_rx_parser: a PHY queue model feeds frames,
//   a monitor captures master-queue writes, and each step compares the
//   captured stream and counters against hand-computed values.
//   Counter expectations follow NUMA_RX_PARSER_STATS_EN when it is defined.
module tb_numa_rx_parser;

`ifdef NUMA_RX_PARSER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        pcie_clk  = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [8:0]  phy_dout  = 9'h000;
  logic        phy_empty = 1'b1;
  logic        phy_rd_en;
  logic [17:0] mst_din;
  logic        mst_full  = 1'b0;
  logic        mst_wr_en;
  logic [15:0] stat_ok;
  logic [15:0] stat_drop;

  int total = 0;
  int bad   = 0;
  int ok_n   = 0;
  int drop_n = 0;
  int edge_n = 0;

  logic [8:0]  phy_q[$];
  int          pop_edges[$];
  logic [17:0] got[$];
  int          wr_edges[$];
  logic [17:0] exp_q[$];

  numa_rx_parser dut (
    .pcie_clk  (pcie_clk),
    .sys_rst_n (sys_rst_n),
    .phy_dout  (phy_dout),
    .phy_empty (phy_empty),
    .phy_rd_en (phy_rd_en),
    .mst_din   (mst_din),
    .mst_full  (mst_full),
    .mst_wr_en (mst_wr_en),
    .stat_ok   (stat_ok),
    .stat_drop (stat_drop)
  );

  always #5 pcie_clk = ~pcie_clk;

  // PHY queue model and master-queue monitor, sampling at the clock edge and
  // updating the PHY outputs 1 time unit later.
  initial begin
    forever begin
      logic popped;
      @(posedge pcie_clk);
      edge_n++;
      popped = phy_rd_en && (phy_q.size() > 0);
      if (sys_rst_n && mst_wr_en) begin
        got.push_back(mst_din);
        wr_edges.push_back(edge_n);
      end
      #1;
      if (popped) begin
        phy_dout = phy_q.pop_front();
        pop_edges.push_back(edge_n);
      end
      phy_empty = (phy_q.size() == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_ok"},   32'(stat_ok),   STATS_EN ? 32'(ok_n)   : 32'd0);
    check({tag, "_stat_drop"}, 32'(stat_drop), STATS_EN ? 32'(drop_n) : 32'd0);
  endtask

  task automatic check_stream(input string tag);
    logic [17:0] g;
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 18'bx;
      check($sformatf("%s_w%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    phy_q.push_back({1'b1, b});
  endtask

  task automatic push_frame(input logic [15:0] etype, input logic [31:0] addr,
                            input logic [15:0] len, input int npay,
                            input logic [7:0] start, input logic [7:0] step,
                            input int npad, input bit with_end);
    logic [7:0] b;
    for (int i = 0; i < 6; i++) push_byte(8'hFF);
    push_byte(8'h02);
    for (int i = 0; i < 4; i++) push_byte(8'h00);
    push_byte(8'h01);
    push_byte(etype[15:8]);
    push_byte(etype[7:0]);
    push_byte(addr[31:24]);
    push_byte(addr[23:16]);
    push_byte(addr[15:8]);
    push_byte(addr[7:0]);
    push_byte(len[15:8]);
    push_byte(len[7:0]);
    b = start;
    for (int i = 0; i < npay; i++) begin
      push_byte(b);
      b = b + step;
    end
    for (int i = 0; i < npad; i++) push_byte(8'hEE);
    if (with_end) phy_q.push_back(9'h000);
  endtask

  // Expected words of a fully delivered, accepted frame.
  task automatic build_exp(input logic [31:0] addr, input int len,
                           input logic [7:0] start, input logic [7:0] step);
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back({2'b10, addr[31:16]});
    exp_q.push_back({2'b00, addr[15:0]});
    b = start;
    for (int k = 0; k < len / 2; k++) begin
      b0 = b;
      b1 = b + step;
      b  = b + step + step;
      exp_q.push_back({(k == len / 2 - 1) ? 2'b01 : 2'b00, b0, b1});
    end
  endtask

  task automatic wait_drain(input string tag);
    int  n;
    logic to;
    n = 0;
    while (phy_q.size() != 0 && n < 4000) begin
      @(posedge pcie_clk);
      n++;
    end
    to = (phy_q.size() != 0);
    repeat (12) @(posedge pcie_clk);
    #2;
    check({tag, "_drain"}, 32'(to), 32'd0);
  endtask

  task automatic wait_got(input string tag, input int n_words);
    int  n;
    logic to;
    n = 0;
    while (got.size() < n_words && n < 400) begin
      @(posedge pcie_clk);
      #2;
      n++;
    end
    to = (got.size() < n_words);
    check({tag, "_wait"}, 32'(to), 32'd0);
  endtask

  task automatic clear_capture();
    got.delete();
    wr_edges.delete();
  endtask

  initial begin
    int   base_pop;
    int   lat;
    int   got_before;
    logic wr_seen;
    logic rd_seen;

    // Reset state, with idle (bit8=0) entries already waiting in the PHY.
    phy_q.push_back(9'h000);
    phy_q.push_back(9'h055);
    repeat (3) @(posedge pcie_clk);
    #2;
    check("rst_mst_din",   32'(mst_din),   32'd0);
    check("rst_mst_wr_en", 32'(mst_wr_en), 32'd0);
    check("rst_phy_rd_en", 32'(phy_rd_en), 32'd0);
    check_stats("rst");
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;
    wait_drain("idle");
    check("idle_no_out", 32'(got.size()), 32'd0);

    // Basic accepted frame, plus pop-to-write latency of the first payload word.
    clear_capture();
    base_pop = pop_edges.size();
    push_frame(16'h3776, 32'h12345678, 16'd4, 4, 8'hAA, 8'h11, 0, 1'b1);
    wait_drain("a");
    exp_q = {18'h21234, 18'h05678, 18'h0AABB, 18'h1CCDD};
    check_stream("a");
    lat = (pop_edges.size() > base_pop + 21 && wr_edges.size() > 2)
          ? (wr_edges[2] - pop_edges[base_pop + 21]) : -1;
    check("a_latency", 32'(lat), 32'd2);
    ok_n++;
    check_stats("a");

    // Wrong ethertype.
    clear_capture();
    push_frame(16'h0800, 32'h12345678, 16'd4, 4, 8'hAA, 8'h11, 0, 1'b1);
    wait_drain("b");
    check("b_no_out", 32'(got.size()), 32'd0);
    drop_n++;
    check_stats("b");

    // Frame ends after 3 of 8 payload bytes: one word, then abort.
    clear_capture();
    push_frame(16'h3776, 32'h12345678, 16'd8, 3, 8'hAA, 8'h11, 0, 1'b1);
    wait_drain("c");
    exp_q = {18'h21234, 18'h05678, 18'h0AABB, 18'h30000};
    check_stream("c");
    drop_n++;
    check_stats("c");

    // Odd, oversized and zero lengths are all dropped silently.
    clear_capture();
    push_frame(16'h3776, 32'h12345678, 16'd5,    5, 8'h01, 8'h01, 0, 1'b1);
    push_frame(16'h3776, 32'h12345678, 16'd1026, 4, 8'h01, 8'h01, 0, 1'b1);
    push_frame(16'h3776, 32'h12345678, 16'd0,    2, 8'h01, 8'h01, 0, 1'b1);
    wait_drain("d");
    check("d_no_out", 32'(got.size()), 32'd0);
    drop_n += 3;
    check_stats("d");

    // Padding after the payload is ignored and does not count as a drop.
    clear_capture();
    push_frame(16'h3776, 32'h12345678, 16'd4, 4, 8'hAA, 8'h11, 3, 1'b1);
    wait_drain("e");
    exp_q = {18'h21234, 18'h05678, 18'h0AABB, 18'h1CCDD};
    check_stream("e");
    ok_n++;
    check_stats("e");

    // Back-pressure for 10 cycles in the middle of the payload.
    clear_capture();
    push_frame(16'h3776, 32'h12345678, 16'd8, 8, 8'h11, 8'h11, 0, 1'b1);
    wait_got("f", 3);
    mst_full = 1'b1;
    #1;
    check("f_rd_en_stall", 32'(phy_rd_en), 32'd0);
    got_before = got.size();
    wr_seen = 1'b0;
    rd_seen = 1'b0;
    repeat (10) begin
      @(posedge pcie_clk);
      #2;
      wr_seen = wr_seen | mst_wr_en;
      rd_seen = rd_seen | phy_rd_en;
    end
    check("f_no_wr_stall",   32'(wr_seen),    32'd0);
    check("f_no_rd_stall",   32'(rd_seen),    32'd0);
    check("f_held_count",    32'(got.size()), 32'(got_before));
    mst_full = 1'b0;
    wait_drain("f");
    exp_q = {18'h21234, 18'h05678, 18'h01122, 18'h03344, 18'h05566, 18'h17788};
    check_stream("f");
    ok_n++;
    check_stats("f");

    // Largest accepted payload.
    clear_capture();
    push_frame(16'h3776, 32'hA5A50F0F, 16'd1024, 1024, 8'h00, 8'h01, 0, 1'b1);
    wait_drain("g");
    build_exp(32'hA5A50F0F, 1024, 8'h00, 8'h01);
    check("g_last_word", 32'(exp_q[exp_q.size() - 1]), 32'h1FEFF);
    check_stream("g");
    ok_n++;
    check_stats("g");

    // Reset in the middle of a payload, then a clean frame.
    clear_capture();
    push_frame(16'h3776, 32'h12345678, 16'd8, 2, 8'hAA, 8'h11, 0, 1'b0);
    wait_got("h_pre", 3);
    repeat (4) @(posedge pcie_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("h_rst_mst_din",   32'(mst_din),   32'd0);
    check("h_rst_mst_wr_en", 32'(mst_wr_en), 32'd0);
    check("h_rst_phy_rd_en", 32'(phy_rd_en), 32'd0);
    ok_n   = 0;
    drop_n = 0;
    check_stats("h_rst");
    phy_q.delete();
    repeat (2) @(posedge pcie_clk);
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;
    clear_capture();
    push_frame(16'h3776, 32'hCAFEF00D, 16'd4, 4, 8'h01, 8'h01, 0, 1'b1);
    wait_drain("h");
    exp_q = {18'h2CAFE, 18'h0F00D, 18'h00102, 18'h10304};
    check_stream("h");
    ok_n++;
    check_stats("h");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/numa_rx_parser.md
NUMA_RX_PARSER -- requirements
Module: numa_rx_parser

Interface
REQ-001 SHALL have parameter ETHERTYPE, default 16'h3776, the accepted frame type.
REQ-002 SHALL have parameter MAX_LEN, default 16'd1024, the largest accepted payload byte count.
REQ-003 SHALL have port pcie_clk  input  1  the single clock for all logic.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port phy_dout  input  9  PHY receive-queue entry; bit8 = frame byte valid, [7:0] = byte.
REQ-006 SHALL have port phy_empty  input  1  PHY receive queue empty.
REQ-007 SHALL have port phy_rd_en  output  1  PHY receive-queue pop; data is valid on phy_dout the cycle after.
REQ-008 SHALL have port mst_din  output  18  master-queue word {flag[1:0], data[15:0]}.
REQ-009 SHALL have port mst_full  input  1  master queue full.
REQ-010 SHALL have port mst_wr_en  output  1  master-queue push.
REQ-011 SHALL have port stat_ok  output  16  count of frames forwarded.
REQ-012 SHALL have port stat_drop  output  16  count of frames dropped.

Function
REQ-013 Frame: the contiguous run of entries with bit8=1; the first entry with bit8=0 ends it.
REQ-014 Frame layout, bytes 0-13: dst MAC, src MAC, ethertype (big-endian); bytes 14-17: addr[31:0]; bytes 18-19: len[15:0]; then payload. All fields big-endian.
REQ-015 Flag encoding: 2'b10 = start, 2'b00 = middle, 2'b01 = end, 2'b11 = abort.
REQ-016 Output per accepted frame, in order: {10, addr[31:16]}, {00, addr[15:0]}, then len/2 payload words, first byte in [15:8]; the last payload word carries flag 01.
REQ-017 States: IDLE, HDR, PAY, SKIP, DROP.
REQ-018 IDLE -> HDR on the first valid byte.
REQ-019 HDR -> DROP if the ethertype differs from ETHERTYPE, or if len = 0, len is odd, or len > MAX_LEN; otherwise HDR -> PAY after byte 19.
REQ-020 PAY -> SKIP after the last payload byte.
REQ-021 SKIP and DROP discard bytes until the frame ends, then go to IDLE.
REQ-022 Header words SHALL be written only once the frame is validated at byte 19; nothing is written for a dropped frame.
REQ-023 Frame end in HDR: drop, no output, return to IDLE.
REQ-024 Frame end in PAY before len bytes: emit exactly one {11, 16'h0000} abort word, count as drop, return to IDLE. A pending odd byte is discarded.
REQ-025 Bytes beyond len (padding, FCS) SHALL be ignored and SHALL NOT count as drop.
REQ-026 Entries with bit8=0 in IDLE SHALL be consumed and ignored.
REQ-027 phy_rd_en = !phy_empty & !mst_full & skid empty.
REQ-028 A word produced while mst_full is high SHALL be held in a one-entry skid register and written on the first cycle mst_full is low; while the skid is occupied, phy_rd_en SHALL be 0.
REQ-029 At most one mst_wr_en per cycle; words SHALL never be lost, duplicated or reordered.
REQ-030 Latency: pop of a payload's second byte -> mst_wr_en two cycles later when mst_full stays low.
REQ-031 Counters SHALL wrap from 16'hFFFF to 0; each frame increments exactly one counter at its end.

Reset
REQ-032 On sys_rst_n low, asynchronously: state IDLE; phy_rd_en, mst_wr_en = 0; mst_din = 18'h0; skid empty; stat_ok, stat_drop = 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no abort word; after release, the remaining tail is treated per REQ-026 until a bit8=1 entry starts a new frame.

Configuration
REQ-034 Macro NUMA_RX_PARSER_STATS_EN SHALL control the frame counters.
REQ-035 With NUMA_RX_PARSER_STATS_EN defined: stat_ok and stat_drop behave per REQ-011, REQ-012 and REQ-031.
REQ-036 Without NUMA_RX_PARSER_STATS_EN: stat_ok and stat_drop SHALL be constant 0, no counter flops, and all other behaviour is identical.

Verification
REQ-037 Frame with ethertype 3776, addr 0x12345678, len 4, payload AA BB CC DD -> words 2_1234, 0_5678, 0_AABB, 1_CCDD; stat_ok = 1.
REQ-038 Same frame with ethertype 0800 -> no mst_wr_en; stat_drop = 1.
REQ-039 len 8 with the frame ending after 3 payload bytes -> 2_hdr, 0_hdr, one payload word, then 3_0000; stat_drop = 1.
REQ-040 mst_full held high for 10 cycles mid-payload -> phy_rd_en = 0 within 1 cycle; output stream identical to the unstalled run.
REQ-041 len 5 and len 1026 -> both dropped, no output.
REQ-042 sys_rst_n pulsed low during PAY -> outputs 0 immediately; the next valid frame is forwarded correctly with counters restarted at 0.
